// File: rtl/regfile_dbg_view.sv
// Register file with two async read ports, one sync write port and a stepping debug viewer.
// Optional macro REGFILE_BYPASS_EN: write-first bypass on the read ports.
module regfile_dbg_view #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int SCAN_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              dbg_next,
   input  logic              dbg_auto,
   output logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_value
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [PRE_W-1:0]  pre_q;
   logic [PRE_W-1:0]  pre_d;
   logic [ADDR_W-1:0] sel_q;
   logic [ADDR_W-1:0] sel_d;
   logic [DATA_W-1:0] value_q;
   logic              next_q;
   logic              armed_q;
   logic              auto_step;
   logic              btn_step;
   logic              wr_ok;

   function automatic logic live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < LIMIT) && !(ZERO_REG != 0 && a == '0);
   endfunction

   assign wr_ok = we && live(waddr);

   always_comb begin
      rdata_a = '0;
      if (live(raddr_a)) rdata_a = regs[raddr_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && waddr == raddr_a) rdata_a = wdata;
`endif
   end

   always_comb begin
      rdata_b = '0;
      if (live(raddr_b)) rdata_b = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && waddr == raddr_b) rdata_b = wdata;
`endif
   end

   // armed_q blocks a level held high across reset from stepping
   assign btn_step = dbg_next && !next_q && armed_q;

   always_comb begin
      pre_d     = pre_q + 1'b1;
      auto_step = 1'b0;
      if (!dbg_auto) begin
         pre_d = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d     = '0;
         auto_step = 1'b1;
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (btn_step || auto_step) begin
         sel_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         pre_q   <= '0;
         sel_q   <= '0;
         value_q <= '0;
         next_q  <= 1'b0;
         armed_q <= !dbg_next;
      end else begin
         if (wr_ok) regs[waddr] <= wdata;
         pre_q   <= pre_d;
         sel_q   <= sel_d;
         value_q <= live(sel_q) ? regs[sel_q] : '0;
         next_q  <= dbg_next;
         armed_q <= armed_q || !dbg_next;
      end
   end

   assign dbg_sel   = sel_q;
   assign dbg_value = value_q;

endmodule

// File: tb/tb_regfile_dbg_view.sv
// Directed bench for regfile_dbg_view: a 16-reg plain instance and a 12-reg zero-reg instance.
module tb_regfile_dbg_view;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [3:0]  waddr = '0;
   logic [15:0] wdata = '0;
   logic [3:0]  raddr_a = '0;
   logic [3:0]  raddr_b = '0;
   logic        dbg_next = 1'b0;
   logic        dbg_auto = 1'b0;
   logic [15:0] a_rdata_a, a_rdata_b, a_value;
   logic [15:0] z_rdata_a, z_rdata_b, z_value;
   logic [3:0]  a_sel, z_sel;

   item_t sb[$];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   regfile_dbg_view #(
      .DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .ZERO_REG(0), .SCAN_DIV(4)
   ) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(a_rdata_a), .rdata_b(a_rdata_b),
      .dbg_next(dbg_next), .dbg_auto(dbg_auto),
      .dbg_sel(a_sel), .dbg_value(a_value)
   );

   regfile_dbg_view #(
      .DATA_W(16), .NUM_REGS(12), .ADDR_W(4), .ZERO_REG(1), .SCAN_DIV(4)
   ) dut_z (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(z_rdata_a), .rdata_b(z_rdata_b),
      .dbg_next(dbg_next), .dbg_auto(dbg_auto),
      .dbg_sel(z_sel), .dbg_value(z_value)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [15:0] e);
      item_t it;
      it.tag = tag;
      it.exp = e;
      sb.push_back(it);
   endtask

   task automatic pop_chk(input logic [15:0] obs);
      item_t it;
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %h required an expected entry", obs);
         return;
      end
      it = sb.pop_front();
      assert (obs === it.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] e, input logic [15:0] obs);
      push(tag, e);
      pop_chk(obs);
   endtask

   initial begin
      logic [15:0] coll;
`ifdef REGFILE_BYPASS_EN
      coll = 16'h5555;
`else
      coll = 16'h0001;
`endif
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_sel", 16'h0, {12'h0, a_sel});
      chk("rst_val", 16'h0, a_value);

      // reset then readback
      we = 1'b1; waddr = 4'd13; wdata = 16'hBEEF;
      cyc();
      we = 1'b0; raddr_a = 4'd13;
      #1;
      chk("wr13", 16'hBEEF, a_rdata_a);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         raddr_a = 4'(i);
         raddr_b = 4'(15 - i);
         push("clr_a", 16'h0);
         push("clr_b", 16'h0);
         #1;
         pop_chk(a_rdata_a);
         pop_chk(a_rdata_b);
      end
      chk("clr_sel", 16'h0, {12'h0, a_sel});
      chk("clr_val", 16'h0, a_value);

      // dual read and collision
      we = 1'b1; waddr = 4'd3; wdata = 16'h1234;
      cyc();
      waddr = 4'd7; wdata = 16'hABCD;
      cyc();
      waddr = 4'd5; wdata = 16'h0001;
      cyc();
      we = 1'b0; raddr_a = 4'd3; raddr_b = 4'd7;
      #1;
      chk("rd_a3", 16'h1234, a_rdata_a);
      chk("rd_b7", 16'hABCD, a_rdata_b);
      we = 1'b1; waddr = 4'd5; wdata = 16'h5555; raddr_a = 4'd5;
      #1;
      chk("coll_a", coll, a_rdata_a);
      chk("coll_z", coll, z_rdata_a);
      cyc();
      we = 1'b0;
      #1;
      chk("post_coll", 16'h5555, a_rdata_a);

      // zero register and out-of-range write
      we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; raddr_a = 4'd0;
      #1;
      chk("z0_same", 16'h0, z_rdata_a);
      cyc();
      we = 1'b0;
      #1;
      chk("z0_after", 16'h0, z_rdata_a);
      chk("a0_after", 16'hFFFF, a_rdata_a);
      we = 1'b1; waddr = 4'd13; wdata = 16'h7777; raddr_a = 4'd13;
      cyc();
      we = 1'b0;
      #1;
      chk("z13", 16'h0, z_rdata_a);
      chk("a13", 16'h7777, a_rdata_a);
      raddr_a = 4'd3; raddr_b = 4'd7;
      #1;
      chk("z_r3", 16'h1234, z_rdata_a);
      chk("z_r7", 16'hABCD, z_rdata_b);
      raddr_a = 4'd5; raddr_b = 4'd1;
      #1;
      chk("z_r5", 16'h5555, z_rdata_a);
      chk("z_r1", 16'h0, z_rdata_b);

      // button stepping
      we = 1'b1; waddr = 4'd1; wdata = 16'h00A5;
      cyc();
      we = 1'b0; dbg_next = 1'b1;
      push("btn_sel1", 16'h1);
      cyc();
      pop_chk({12'h0, a_sel});
      push("btn_val_a", 16'h00A5);
      push("btn_val_z", 16'h00A5);
      cyc();
      pop_chk(a_value);
      pop_chk(z_value);
      for (int i = 0; i < 8; i++) cyc();
      chk("btn_hold", 16'h1, {12'h0, a_sel});
      dbg_next = 1'b0;
      cyc();
      for (int i = 0; i < 15; i++) begin
         dbg_next = 1'b1;
         cyc();
         dbg_next = 1'b0;
         cyc();
      end
      chk("btn_wrap_a", 16'h0, {12'h0, a_sel});
      chk("btn_wrap_z", 16'h4, {12'h0, z_sel});

      // auto-scan with a coincident button edge
      rst = 1'b1;
      cyc();
      rst = 1'b0; dbg_auto = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         dbg_next = (k == 8);
         push("auto_sel", 16'(k / 4));
         cyc();
         dbg_next = 1'b0;
         pop_chk({12'h0, a_sel});
      end
      dbg_auto = 1'b0;
      chk("auto_z", 16'h3, {12'h0, z_sel});

      // reset mid-scan
      rst = 1'b1;
      cyc();
      rst = 1'b0; dbg_auto = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
      chk("mid_pre", 16'h1, {12'h0, a_sel});
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst", 16'h0, {12'h0, a_sel});
      for (int k = 1; k <= 4; k++) begin
         push("mid_step", (k == 4) ? 16'h1 : 16'h0);
         cyc();
         pop_chk({12'h0, a_sel});
      end
      dbg_auto = 1'b0;

      // button held through reset release
      dbg_next = 1'b1; rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      cyc();
      chk("held_rst", 16'h0, {12'h0, a_sel});
      dbg_next = 1'b0;
      cyc();
      dbg_next = 1'b1;
      cyc();
      chk("fresh_edge", 16'h1, {12'h0, a_sel});
      dbg_next = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
